// File: rtl/regif_pkg.sv
// Shared types and helpers for the serial register interface (read and write paths).
package regif_pkg;

   typedef enum logic [1:0] {IDLE, ISSUE, FETCH, READY} rb_state_t;

   function automatic int regif_addr_width(input int num_reg);
      return (num_reg <= 1) ? 1 : $clog2(num_reg);
   endfunction

endpackage

// File: rtl/rb_valid_pipe.sv
// Delays the register-file read strobe by the read latency; its output marks the cycle
// read_data is valid. A synchronous flush cancels any read still in flight.
module rb_valid_pipe #(
   parameter int depth = 1
) (
   input  logic clk,
   input  logic flush,
   input  logic din,
   output logic dout
);

   logic [depth-1:0] vld_p;

   always_ff @(posedge clk) begin
      if (flush) begin
         vld_p <= '0;
      end else begin
         vld_p[0] <= din;
         for (int i = 1; i < depth; i++) vld_p[i] <= vld_p[i-1];
      end
   end

   assign dout = vld_p[depth-1];

endmodule

// File: rtl/reg_readback.sv
// Register readback: prefetches register words in address order into a one-word buffer
// for the transmitter. Optional sticky underrun flag when REG_READBACK_UNDERRUN_EN is defined.
module reg_readback
   import regif_pkg::*;
#(
   parameter int width        = 16,
   parameter int num_reg      = 4,
   parameter int read_latency = 1
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 new_transfer,
   input  logic                                 transfer_done,
   input  logic                                 data_req,
   output logic [width-1:0]                     data_out,
   output logic                                 data_valid,
   output logic                                 read_done,
   output logic [regif_addr_width(num_reg)-1:0] read_addr,
   output logic                                 read_enable,
   input  logic [width-1:0]                     read_data
`ifdef REG_READBACK_UNDERRUN_EN
   ,
   output logic                                 underrun
`endif
);

   localparam int addr_width = regif_addr_width(num_reg);
   localparam logic [addr_width-1:0] last_addr = addr_width'(num_reg - 1);

   rb_state_t state, state_next;
   logic      capture;
   logic      flush;
   logic      consume;

   assign read_enable = (state == ISSUE);
   assign data_valid  = (state == READY);
   assign consume     = data_req & (state == READY);
   // Any restart, stop or reset drops the outstanding read so a stale word is never captured.
   assign flush       = rst | new_transfer | transfer_done;

   rb_valid_pipe #(
      .depth (read_latency)
   ) u_valid_pipe (
      .clk   (clk),
      .flush (flush),
      .din   (read_enable),
      .dout  (capture)
   );

   always_comb begin
      state_next = state;
      if (new_transfer) begin
         state_next = ISSUE;
      end else if (transfer_done) begin
         state_next = IDLE;
      end else begin
         case (state)
            ISSUE:   state_next = FETCH;
            FETCH:   if (capture) state_next = READY;
            READY:   if (data_req) state_next = ISSUE;
            default: state_next = state;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         read_addr <= '0;
         data_out  <= '0;
         read_done <= 1'b0;
      end else begin
         state     <= state_next;
         read_done <= transfer_done;
         if (new_transfer) begin
            read_addr <= '0;
         end else if (!transfer_done && consume) begin
            read_addr <= (read_addr == last_addr) ? '0 : read_addr + 1'b1;
         end
         if (!new_transfer && !transfer_done && (state == FETCH) && capture) begin
            data_out <= read_data;
         end
      end
   end

`ifdef REG_READBACK_UNDERRUN_EN
   always_ff @(posedge clk) begin
      if (rst || new_transfer) begin
         underrun <= 1'b0;
      end else if (data_req && ((state == ISSUE) || (state == FETCH))) begin
         underrun <= 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_reg_readback.sv
// Scoreboard bench for reg_readback with a 3-cycle register-file model; expected words are
// queued at stimulus time and checked by a monitor whenever a new word becomes valid.
module tb_reg_readback;

   localparam int LAT = 3;

   logic        clk;
   logic        rst;
   logic        new_transfer;
   logic        transfer_done;
   logic        data_req;
   logic [15:0] data_out;
   logic        data_valid;
   logic        read_done;
   logic [1:0]  read_addr;
   logic        read_enable;
   logic [15:0] read_data;
`ifdef REG_READBACK_UNDERRUN_EN
   logic        underrun;
`endif

   reg_readback #(
      .width        (16),
      .num_reg      (4),
      .read_latency (LAT)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .new_transfer  (new_transfer),
      .transfer_done (transfer_done),
      .data_req      (data_req),
      .data_out      (data_out),
      .data_valid    (data_valid),
      .read_done     (read_done),
      .read_addr     (read_addr),
      .read_enable   (read_enable),
      .read_data     (read_data)
`ifdef REG_READBACK_UNDERRUN_EN
      ,
      .underrun      (underrun)
`endif
   );

   logic [15:0] regs [0:3] = '{16'h00A1, 16'h00B2, 16'h00C3, 16'h00D4};
   logic [15:0] rd_p1, rd_p2, rd_p3;
   int          cyc = 0;
   int          n_cmp = 0;
   int          n_err = 0;
   logic [17:0] exp_q[$];
   logic [17:0] mon_e;
   logic        dv_prev = 1'b0;
   logic        re_prev = 1'b0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Register file: data for a strobed read appears LAT cycles later, garbage otherwise.
   always @(posedge clk) begin
      cyc   <= cyc + 1;
      rd_p1 <= read_enable ? regs[read_addr] : 16'hDEAD;
      rd_p2 <= rd_p1;
      rd_p3 <= rd_p2;
   end
   assign read_data = rd_p3;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push_exp(input int i);
      logic [1:0] a;
      a = 2'(i % 4);
      exp_q.push_back({a, regs[i % 4]});
   endtask

   task automatic wait_valid(input string name);
      int n;
      n = 0;
      while (!data_valid && n < 20) begin
         step();
         n++;
      end
      check(name, {31'd0, data_valid}, 32'd1);
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         if (data_valid && !dv_prev) begin
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL unexpected_word: got %0h at addr %0d, expected none", data_out, read_addr);
            end else begin
               mon_e = exp_q.pop_front();
               check("word_data", {16'd0, data_out}, {16'd0, mon_e[15:0]});
               check("word_addr", {30'd0, read_addr}, {30'd0, mon_e[17:16]});
            end
         end
         if (read_enable) check("re_no_back_to_back", {31'd0, re_prev}, 32'd0);
      end
      dv_prev = data_valid;
      re_prev = read_enable;
   end

   initial begin
      int last;
      rst = 1'b1; new_transfer = 1'b0; transfer_done = 1'b0; data_req = 1'b0;
      repeat (3) step();
      check("rst_data_valid", {31'd0, data_valid}, 32'd0);
      check("rst_read_enable", {31'd0, read_enable}, 32'd0);
      check("rst_read_addr", {30'd0, read_addr}, 32'd0);
      check("rst_data_out", {16'd0, data_out}, 32'd0);
      check("rst_read_done", {31'd0, read_done}, 32'd0);
`ifdef REG_READBACK_UNDERRUN_EN
      check("rst_underrun", {31'd0, underrun}, 32'd0);
`endif
      rst = 1'b0;

      // Latency: new_transfer in cycle 10, strobe in 11, word valid in 15.
      while (cyc < 10) step();
      new_transfer = 1'b1;
      push_exp(0);
      step();
      new_transfer = 1'b0;
      check("re_at_11", {31'd0, read_enable}, 32'd1);
      check("addr_at_11", {30'd0, read_addr}, 32'd0);
      step();
      check("re_at_12", {31'd0, read_enable}, 32'd0);
      step(); step();
      check("dv_at_14", {31'd0, data_valid}, 32'd0);
      step();
      check("dv_at_15", {31'd0, data_valid}, 32'd1);
      check("dout_at_15", {16'd0, data_out}, 32'h00A1);

      // Address-ordered sequence with wrap: B2, C3, D4, A1.
      for (int k = 1; k <= 4; k++) begin
         data_req = 1'b1;
         push_exp(k);
         step();
         data_req = 1'b0;
         wait_valid("seq_valid");
      end

      // data_req while no word is held must not advance the address.
      data_req = 1'b1;
      push_exp(1);
      step();
      step();
      data_req = 1'b0;
`ifdef REG_READBACK_UNDERRUN_EN
      check("underrun_set", {31'd0, underrun}, 32'd1);
`endif
      wait_valid("ignored_req_valid");
      check("ignored_req_addr", {30'd0, read_addr}, 32'd1);
`ifdef REG_READBACK_UNDERRUN_EN
      check("underrun_held", {31'd0, underrun}, 32'd1);
`endif

      // Restart with data_req held high: one word per 2+LAT cycles, no skipped address.
      new_transfer = 1'b1;
      data_req = 1'b1;
      push_exp(0);
      step();
      new_transfer = 1'b0;
`ifdef REG_READBACK_UNDERRUN_EN
      check("underrun_cleared", {31'd0, underrun}, 32'd0);
`endif
      last = 0;
      for (int k = 0; k <= 4; k++) begin
         wait_valid("stream_valid");
         if (k > 0) check("stream_period", 32'(cyc - last), 32'(2 + LAT));
         last = cyc;
         if (k < 4) push_exp(k + 1);
         else data_req = 1'b0;
         step();
      end

      // transfer_done during FETCH: one read_done pulse, the pending word is dropped.
      data_req = 1'b1;
      step();
      data_req = 1'b0;
      step();
      transfer_done = 1'b1;
      step();
      transfer_done = 1'b0;
      check("done_pulse", {31'd0, read_done}, 32'd1);
      check("done_dv", {31'd0, data_valid}, 32'd0);
      check("done_addr_hold", {30'd0, read_addr}, 32'd1);
      check("done_dout_hold", {16'd0, data_out}, 32'h00A1);
      step();
      check("done_pulse_end", {31'd0, read_done}, 32'd0);
      for (int k = 0; k < 5; k++) begin
         check("done_no_capture", {31'd0, data_valid}, 32'd0);
         step();
      end

      // new_transfer and transfer_done together: restart wins, read_done still pulses.
      new_transfer = 1'b1;
      transfer_done = 1'b1;
      push_exp(0);
      step();
      new_transfer = 1'b0;
      transfer_done = 1'b0;
      check("both_read_done", {31'd0, read_done}, 32'd1);
      check("both_read_enable", {31'd0, read_enable}, 32'd1);
      check("both_addr", {30'd0, read_addr}, 32'd0);
      wait_valid("both_valid");

      // rst mid-FETCH: everything clears and the old read is never captured.
      data_req = 1'b1;
      step();
      data_req = 1'b0;
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("rstf_data_out", {16'd0, data_out}, 32'd0);
      check("rstf_data_valid", {31'd0, data_valid}, 32'd0);
      check("rstf_read_enable", {31'd0, read_enable}, 32'd0);
      check("rstf_read_addr", {30'd0, read_addr}, 32'd0);
      check("rstf_read_done", {31'd0, read_done}, 32'd0);
`ifdef REG_READBACK_UNDERRUN_EN
      check("rstf_underrun", {31'd0, underrun}, 32'd0);
`endif
      for (int k = 0; k < 6; k++) begin
         step();
         check("rstf_no_capture", {15'd0, data_valid, data_out}, 32'd0);
      end

      check("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1);
   end

endmodule
